// File: rtl/univ_shift_register.sv
// Universal shift register with single-step and multi-step burst operation; one-cycle step latency.
// No backpressure: start is ignored (not queued) while a burst is running or completing.
module univ_shift_register #(
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] d,
   input  logic             start,
   input  logic [AW-1:0]    amt,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SR   = 3'b001;
   localparam logic [2:0] M_SL   = 3'b010;
   localparam logic [2:0] M_ROR  = 3'b011;
   localparam logic [2:0] M_ROL  = 3'b100;
   localparam logic [2:0] M_ASR  = 3'b101;
   localparam logic [2:0] M_LOAD = 3'b110;
   localparam logic [2:0] M_CLR  = 3'b111;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [2:0]       mode_lat, mode_lat_nxt, op;
   logic [AW-1:0]    cnt, cnt_nxt;
   logic             apply;
   logic             is_shift;
   logic [WIDTH-1:0] q_step;
   logic             sout_step;

   assign is_shift = (mode != M_HOLD) && (mode <= M_ASR);

   // cnt holds the number of steps still owed while in RUN
   always_comb begin
      state_nxt    = state;
      mode_lat_nxt = mode_lat;
      cnt_nxt      = cnt;
      op           = mode;
      apply        = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               mode_lat_nxt = mode;
               state_nxt    = DONE;
               cnt_nxt      = '0;
               if (!is_shift) begin
                  apply = 1'b1;
               end else if (amt != '0) begin
                  apply = 1'b1;
                  if (amt > AW'(1)) begin
                     state_nxt = RUN;
                     cnt_nxt   = amt - AW'(1);
                  end
               end
            end else begin
               apply = en;
            end
         end
         RUN: begin
            op      = mode_lat;
            apply   = 1'b1;
            cnt_nxt = cnt - AW'(1);
            if (cnt == AW'(1)) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      q_step    = q;
      sout_step = sout;
      case (op)
         M_SR:  begin q_step = {sin_r, q[WIDTH-1:1]};      sout_step = q[0];       end
         M_SL:  begin q_step = {q[WIDTH-2:0], sin_l};      sout_step = q[WIDTH-1]; end
         M_ROR: begin q_step = {q[0], q[WIDTH-1:1]};       sout_step = q[0];       end
         M_ROL: begin q_step = {q[WIDTH-2:0], q[WIDTH-1]}; sout_step = q[WIDTH-1]; end
         M_ASR: begin q_step = {q[WIDTH-1], q[WIDTH-1:1]}; sout_step = q[0];       end
         M_LOAD: q_step = d;
         M_CLR:  q_step = '0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         mode_lat <= M_HOLD;
         cnt      <= '0;
         q        <= '0;
         sout     <= 1'b0;
      end else begin
         state    <= state_nxt;
         mode_lat <= mode_lat_nxt;
         cnt      <= cnt_nxt;
         if (apply) begin
            q    <= q_step;
            sout <= sout_step;
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_univ_shift_register.sv
// Directed self-checking bench for univ_shift_register at WIDTH=8.
module tb_univ_shift_register;

   localparam int W  = 8;
   localparam int AW = 4;

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SR   = 3'b001;
   localparam logic [2:0] M_SL   = 3'b010;
   localparam logic [2:0] M_ROR  = 3'b011;
   localparam logic [2:0] M_ROL  = 3'b100;
   localparam logic [2:0] M_ASR  = 3'b101;
   localparam logic [2:0] M_LOAD = 3'b110;
   localparam logic [2:0] M_CLR  = 3'b111;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [2:0]    mode;
   logic          sin_r;
   logic          sin_l;
   logic [W-1:0]  d;
   logic          start;
   logic [AW-1:0] amt;
   logic [W-1:0]  q;
   logic          sout;
   logic          busy;
   logic          done;

   int tests = 0;
   int fails = 0;

   univ_shift_register #(.WIDTH(W), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
      .d(d), .start(start), .amt(amt), .q(q), .sout(sout), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      en = 0; mode = M_HOLD; sin_r = 0; sin_l = 0; d = '0; start = 0; amt = '0;
   endtask

   task automatic load(input logic [W-1:0] val);
      en = 1; mode = M_LOAD; d = val; start = 0;
      tick();
      en = 0; mode = M_HOLD;
   endtask

   task automatic do_reset();
      rst_n = 0;
      #3;
      rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      #2;
      tests++;
      if (q !== 8'h00 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_initial: q=%h sout=%b busy=%b done=%b, want 00 0 0 0", q, sout, busy, done);
      end
      rst_n = 1;
      tick();
      load(8'hFF);
      #2;
      rst_n = 0;
      #1;
      tests++;
      if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_async: q=%h busy=%b done=%b, want 00 0 0", q, busy, done);
      end
      #2;
      rst_n = 1;
      tick();
   endtask

   task automatic test_sr_serial();
      logic          seq [7];
      logic [W-1:0]  exp [7];
      seq = '{1, 1, 0, 1, 0, 0, 1};
      exp = '{8'h80, 8'hC0, 8'h60, 8'hB0, 8'h58, 8'h2C, 8'h96};
      do_reset();
      en = 1; mode = M_SR;
      for (int i = 0; i < 7; i++) begin
         sin_r = seq[i];
         tick();
         tests++;
         if (q !== exp[i] || sout !== 1'b0) begin
            fails++;
            $display("FAIL sr_serial[%0d]: q=%h sout=%b, want %h 0", i, q, sout, exp[i]);
         end
      end
      idle_inputs();
   endtask

   task automatic test_rol_burst();
      int n = 0;
      int busy_cnt = 0;
      load(8'hA5);
      start = 1; mode = M_ROL; amt = 3;
      tick();
      start = 0;
      while (!done && n < 20) begin
         if (busy) busy_cnt++;
         tick();
         n++;
      end
      tests++;
      if (done !== 1'b1 || q !== 8'h2D || sout !== 1'b1 || busy !== 1'b0 || busy_cnt != 2) begin
         fails++;
         $display("FAIL rol_burst: done=%b q=%h sout=%b busy=%b busy_cycles=%0d, want 1 2d 1 0 2",
                  done, q, sout, busy, busy_cnt);
      end
      tick();
      tests++;
      if (done !== 1'b0 || q !== 8'h2D) begin
         fails++;
         $display("FAIL rol_done_pulse: done=%b q=%h, want 0 2d", done, q);
      end
      idle_inputs();
   endtask

   task automatic test_asr_burst();
      int n = 0;
      load(8'h90);
      start = 1; mode = M_ASR; amt = 4;
      tick();
      start = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      tests++;
      if (done !== 1'b1 || q !== 8'hF9 || n + 1 != 4) begin
         fails++;
         $display("FAIL asr_burst: done=%b q=%h steps=%0d, want 1 f9 4", done, q, n + 1);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_ror_full();
      int n = 0;
      load(8'h3C);
      start = 1; mode = M_ROR; amt = 8;
      tick();
      // scramble every ignored input for the rest of the burst
      start = 1; mode = M_SL; en = 1; d = 8'hFF; amt = 1; sin_l = 1;
      while (!done && n < 30) begin
         tick();
         n++;
      end
      tests++;
      if (done !== 1'b1 || q !== 8'h3C || n + 1 != 8) begin
         fails++;
         $display("FAIL ror_full: done=%b q=%h steps=%0d, want 1 3c 8", done, q, n + 1);
      end
      en = 0; mode = M_HOLD;
      tick();
      start = 0;
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h3C) begin
         fails++;
         $display("FAIL ror_start_in_done: done=%b busy=%b q=%h, want 0 0 3c", done, busy, q);
      end
      tick();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h3C) begin
         fails++;
         $display("FAIL ror_not_queued: done=%b busy=%b q=%h, want 0 0 3c", done, busy, q);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_burst();
      int bad = 0;
      load(8'h0F);
      start = 1; mode = M_SL; amt = 5;
      tick();
      start = 0;
      tick();
      #2;
      rst_n = 0;
      #1;
      tests++;
      if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_burst: q=%h busy=%b done=%b, want 00 0 0", q, busy, done);
      end
      #3;
      rst_n = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h00) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL reset_no_done: %0d bad cycles after release, want 0", bad);
      end
      idle_inputs();
   endtask

   task automatic test_amt_zero();
      int seen_busy = 0;
      load(8'h5A);
      start = 1; mode = M_SR; amt = 0; sin_r = 1;
      tick();
      start = 0;
      if (busy) seen_busy++;
      tests++;
      if (q !== 8'h5A || done !== 1'b1) begin
         fails++;
         $display("FAIL amt_zero: q=%h done=%b, want 5a 1", q, done);
      end
      tick();
      if (busy) seen_busy++;
      tests++;
      if (q !== 8'h5A || done !== 1'b0 || seen_busy != 0) begin
         fails++;
         $display("FAIL amt_zero_after: q=%h done=%b busy_cycles=%0d, want 5a 0 0", q, done, seen_busy);
      end
      idle_inputs();
   endtask

   task automatic test_start_en_priority();
      load(8'h81);
      start = 1; en = 1; mode = M_SR; amt = 1; sin_r = 0;
      tick();
      start = 0;
      tests++;
      if (q !== 8'h40 || sout !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL start_priority: q=%h sout=%b done=%b busy=%b, want 40 1 1 0", q, sout, done, busy);
      end
      tick();
      tests++;
      if (q !== 8'h40 || done !== 1'b0) begin
         fails++;
         $display("FAIL hold_in_done: q=%h done=%b, want 40 0", q, done);
      end
      tick();
      tests++;
      if (q !== 8'h20 || sout !== 1'b0) begin
         fails++;
         $display("FAIL en_after_done: q=%h sout=%b, want 20 0", q, sout);
      end
      idle_inputs();
   endtask

   task automatic test_single_modes();
      logic [2:0]   m  [6];
      logic [W-1:0] eq [6];
      logic         es [6];
      logic         ee [6];
      m  = '{M_SL,  M_ROR, M_ROL, M_ASR, M_CLR, M_SR};
      ee = '{1,     1,     1,     1,     1,     0};
      eq = '{8'h2D, 8'h96, 8'h2D, 8'h16, 8'h00, 8'h00};
      es = '{1,     1,     1,     1,     1,     1};
      load(8'h96);
      sin_l = 1; sin_r = 1;
      for (int i = 0; i < 6; i++) begin
         mode = m[i]; en = ee[i];
         tick();
         tests++;
         if (q !== eq[i] || sout !== es[i]) begin
            fails++;
            $display("FAIL single_mode[%0d]: q=%h sout=%b, want %h %b", i, q, sout, eq[i], es[i]);
         end
      end
      en = 0; start = 1; mode = M_LOAD; d = 8'h77; amt = 5;
      tick();
      start = 0;
      tests++;
      if (q !== 8'h77 || done !== 1'b1 || busy !== 1'b0 || sout !== 1'b1) begin
         fails++;
         $display("FAIL start_load: q=%h done=%b busy=%b sout=%b, want 77 1 0 1", q, done, busy, sout);
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_sr_serial();
      test_rol_burst();
      test_asr_burst();
      test_ror_full();
      test_reset_mid_burst();
      test_amt_zero();
      test_start_en_priority();
      test_single_modes();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
